// File: rtl/fdtd_pkg.sv
// Shared FDTD types and helpers for the E- and H-side update pipelines.
// Latency: none (types, constants and a combinational product-cut function).
// Backpressure: not applicable.
package fdtd_pkg;

  localparam int FDTD_W          = 32;
  localparam int FDTD_CELL_CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fdtd_state_e;

  // Per-cell tag travelling alongside the datapath through every stage
  typedef struct packed {
    logic [FDTD_CELL_CNT_W-1:0] index;
    logic                       is_src;
    logic                       is_pec;
    logic                       is_last;
    logic                       valid;
  } fdtd_tag_t;

  // Keep the product sign bit plus slice [cut_lt:cut_rt]; plain floor, no rounding/saturation.
  // The slice is sign-extended from its own MSB when it is narrower than FDTD_W-1 bits.
  function automatic logic signed [FDTD_W-1:0] fdtd_cut(
    input logic signed [2*FDTD_W-1:0] product,
    input int                         cut_lt,
    input int                         cut_rt
  );
    logic signed [2*FDTD_W-1:0] slice;
    int                         ext_sh;
    ext_sh = 2*FDTD_W - 1 - (cut_lt - cut_rt);
    slice  = product >>> cut_rt;
    slice  = slice <<< ext_sh;
    slice  = slice >>> ext_sh;
    return {product[2*FDTD_W-1], slice[FDTD_W-2:0]};
  endfunction

endpackage

// File: rtl/fdtd_pipe_mult.sv
// Registered signed W x W -> 2W multiplier with clock enable.
// Latency: one cycle from operands to p when en is high.
// Backpressure: en low holds the product register.
module fdtd_pipe_mult #(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  logic signed [2*W-1:0] p_d;
  logic signed [2*W-1:0] p_q;

  // Next product: full-width signed multiply, held while disabled
  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = (2*W)'(a) * (2*W)'(b);
    end
  end

  // Product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/fdtd_calc_ez_stream.sv
// Streaming 1-D FDTD Ez update: cut(ceze*Ez_old) + cut(cezh*(Hy[i]-Hy[i-1])), PEC at cell 0, additive source at src_idx.
// Latency: three register stages; a cell handshaken in one cycle shows out_valid three cycles later, 1 cell/cycle.
// Backpressure: out_valid && !out_ready freezes all stages and drops in_ready; Ez_n_o/out_last hold stable.
module fdtd_calc_ez_stream
  import fdtd_pkg::*;
#(
  parameter int FDTD_DATA_WIDTH = FDTD_W,
  parameter int CUT_LT          = 51,
  parameter int CUT_RT          = 21,
  parameter int CELL_CNT_W      = FDTD_CELL_CNT_W
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              start,
  input  logic        [CELL_CNT_W-1:0]      n_cells,
  input  logic        [CELL_CNT_W-1:0]      src_idx,
  input  logic signed [FDTD_DATA_WIDTH-1:0] src_val,
  input  logic signed [FDTD_DATA_WIDTH-1:0] ceze,
  input  logic signed [FDTD_DATA_WIDTH-1:0] cezh,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [FDTD_DATA_WIDTH-1:0] Ez_old_i,
  input  logic signed [FDTD_DATA_WIDTH-1:0] Hy_i,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [FDTD_DATA_WIDTH-1:0] Ez_n_o,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
);

  localparam int W = FDTD_DATA_WIDTH;

  // Frame control
  fdtd_state_e            state_q;
  logic [CELL_CNT_W-1:0]  cnt_q;
  logic [CELL_CNT_W-1:0]  n_cells_q;
  logic [CELL_CNT_W-1:0]  src_idx_q;
  logic [CELL_CNT_W-1:0]  last_idx;
  logic signed [W-1:0]    src_val_q;
  logic signed [W-1:0]    hy_prev_q;
  logic                   done_zero_q;

  // Handshake / pipeline control
  logic stall;
  logic en;
  logic in_fire;
  logic out_fire;
  logic frame_end;

  // S1
  logic signed [W-1:0] diff_d,   diff_q;
  logic signed [W-1:0] ez_old_d, ez_old_q;
  fdtd_tag_t           tag1_d,   tag1_q;

  // S2
  logic signed [2*W-1:0] p_ez;
  logic signed [2*W-1:0] p_hy;
  fdtd_tag_t             tag2_d, tag2_q;

  // S3 (output register)
  logic                  out_valid_d, out_valid_q;
  logic signed [W-1:0]   ez_d,        ez_q;
  logic                  out_last_d,  out_last_q;
  logic [CELL_CNT_W-1:0] out_idx_d,   out_idx_q;
  logic signed [W-1:0]   cut_ez;
  logic signed [W-1:0]   cut_hy;
  logic signed [W-1:0]   ez_new;

  assign last_idx  = n_cells_q - CELL_CNT_W'(1);
  assign stall     = out_valid_q && !out_ready;
  assign en        = !stall;
  assign in_ready  = (state_q == RUN) && !stall;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign frame_end = out_fire && (out_idx_q == last_idx);

  // Frame FSM: start sampling, input counter, Hy[i-1] history, zero-length done
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_cells_q   <= '0;
      src_idx_q   <= '0;
      src_val_q   <= '0;
      hy_prev_q   <= '0;
      done_zero_q <= 1'b0;
    end else begin
      done_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            n_cells_q <= n_cells;
            src_idx_q <= src_idx;
            src_val_q <= src_val;
            cnt_q     <= '0;
            hy_prev_q <= '0;
            if (n_cells == '0) begin
              done_zero_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            hy_prev_q <= Hy_i;
            cnt_q     <= cnt_q + CELL_CNT_W'(1);
            if (cnt_q == last_idx) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (frame_end) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_zero_q || ((state_q == DRAIN) && frame_end);

  // S1 next: spatial difference of Hy and the cell's role flags
  always_comb begin
    diff_d   = diff_q;
    ez_old_d = ez_old_q;
    tag1_d   = tag1_q;
    if (en) begin
      diff_d         = Hy_i - hy_prev_q;
      ez_old_d       = Ez_old_i;
      tag1_d.index   = FDTD_CELL_CNT_W'(cnt_q);
      tag1_d.is_pec  = (cnt_q == '0);
      tag1_d.is_src  = (cnt_q == src_idx_q);
      tag1_d.is_last = (cnt_q == last_idx);
      tag1_d.valid   = in_fire;
    end
  end

  // S1 registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      diff_q   <= '0;
      ez_old_q <= '0;
      tag1_q   <= '0;
    end else begin
      diff_q   <= diff_d;
      ez_old_q <= ez_old_d;
      tag1_q   <= tag1_d;
    end
  end

  // S2: both products registered inside the multipliers
  fdtd_pipe_mult #(.W(W)) u_mult_ez (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (en),
    .a     (ceze),
    .b     (ez_old_q),
    .p     (p_ez)
  );

  fdtd_pipe_mult #(.W(W)) u_mult_hy (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (en),
    .a     (cezh),
    .b     (diff_q),
    .p     (p_hy)
  );

  // S2 tag next: follows the products
  always_comb begin
    tag2_d = tag2_q;
    if (en) begin
      tag2_d = tag1_q;
    end
  end

  // S2 tag register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag2_q <= '0;
    end else begin
      tag2_q <= tag2_d;
    end
  end

  // S3 next: cut both products, wrap-add, add source, then force PEC
  always_comb begin
    cut_ez = fdtd_cut(p_ez, CUT_LT, CUT_RT);
    cut_hy = fdtd_cut(p_hy, CUT_LT, CUT_RT);
    ez_new = cut_ez + cut_hy;
    if (tag2_q.is_src) begin
      ez_new = ez_new + src_val_q;
    end
    if (tag2_q.is_pec) begin
      ez_new = '0;
    end

    out_valid_d = out_valid_q;
    ez_d        = ez_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    if (en) begin
      out_valid_d = tag2_q.valid;
      out_last_d  = tag2_q.valid && tag2_q.is_last;
      if (tag2_q.valid) begin
        ez_d      = ez_new;
        out_idx_d = CELL_CNT_W'(tag2_q.index);
      end
    end
  end

  // S3 output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      ez_q        <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ez_q        <= ez_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Ez_n_o    = ez_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/fdtd_calc_ez_stream.md
# fdtd_calc_ez_stream

Streaming 1-D FDTD electric-field update engine, the E-side counterpart of the Hy update path. It consumes one cell per handshake (old Ez plus the freshly updated Hy), computes Ez_n[i] = cut(ceze·Ez_old[i]) + cut(cezh·(Hy[i] − Hy[i−1])), and applies a PEC boundary at cell 0 and an additive hard source at a programmable cell. Results leave on a valid/ready stream. It sits between the Hy update output / field memory reader and the Ez write-back path in the FDTD accelerator plugin.

## Interface
- FDTD_DATA_WIDTH, 32, field/coefficient word width (signed Q-format)
- CUT_LT, 51, MSB of product slice kept after multiply
- CUT_RT, 21, LSB of product slice kept (fractional bits of coefficients)
- CELL_CNT_W, 10, width of cell count/index
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- start  in  1  frame start pulse, honoured only in IDLE
- n_cells  in  CELL_CNT_W  cells in frame, sampled on start
- src_idx  in  CELL_CNT_W  source cell index, sampled on start
- src_val  in  FDTD_DATA_WIDTH  signed source value, sampled on start
- ceze, cezh  in  FDTD_DATA_WIDTH each  signed coefficients, held stable for the frame
- in_valid / in_ready  in / out  1  input handshake
- Ez_old_i, Hy_i  in  FDTD_DATA_WIDTH each  signed cell operands
- out_valid / out_ready  out / in  1  output handshake
- Ez_n_o  out  FDTD_DATA_WIDTH  signed updated Ez
- out_last  out  1  marks cell n_cells−1
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at frame end

## Operation
- FSM: IDLE → RUN on start with n_cells≠0. RUN → DRAIN when the n_cells-th input is accepted. DRAIN → IDLE when the last output handshakes, with a done pulse in that same cycle.
- start with n_cells==0: done pulses next cycle and the FSM stays IDLE.
- start outside IDLE is ignored.
- On start: clear the input cell counter and set Hy_prev to 0.
- Input transfer: in_valid && in_ready. in_ready = (state==RUN) && !stall.
- Per accepted cell i, on the transfer:
  - diff = Hy_i − Hy_prev, wrapping at FDTD_DATA_WIDTH.
  - Hy_prev <= Hy_i.
  - Counter increments.
- Cut: cut(p) = {p[2W−1], p[CUT_LT:CUT_RT]}. This is truncation (floor), with no rounding or saturation.
- Final add: wraps, two's complement.
- i == src_idx: src_val is added after the sum, wrapping. A src_idx ≥ n_cells never matches.
- i == 0 (PEC): Ez_n_o is forced to 0 and the source is ignored.
- out_last is asserted with the cell whose index equals n_cells−1.

## Timing
- Pipeline of three stages, with one global enable en = !stall, where stall = out_valid && !out_ready.
  - S1: diff, Ez_old, and cell tag (index, is_src, is_pec, is_last) registered.
  - S2: both signed products registered.
  - S3: cut, add, and source/PEC applied into the output register.
- Latency: an input accepted at edge k gives out_valid at edge k+3 when there is no stall.
- Throughput: 1 cell/cycle.
- Stalls freeze all stages. Ez_n_o and out_last hold stable while out_valid && !out_ready.
- Bubbles, i.e. in_valid low, propagate as invalid stage slots and never produce output.
- Reset values:
  - Outputs: out_valid, Ez_n_o, out_last, busy, done, in_ready are 0.
  - State: IDLE.
  - Internal: all stage valids 0.
- Reset mid-frame discards all in-flight cells; no done is produced.

## Structure
- Package fdtd_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - stage-tag struct (index, is_src, is_pec, is_last, valid)
  - function fdtd_cut(product, CUT_LT, CUT_RT), shared with the H-side path
- Sub-module fdtd_pipe_mult: registered signed W×W→2W multiply with enable. It is instantiated twice, in place of vendor IP, so the block is self-contained for simulation.

## Test plan
Coefficients of 1.0 and 0.5 are 1<<21 and 1<<20 (CUT_RT=21).
- Basic frame:
  - Setup: n_cells=4, ceze=cezh=1<<21, src_idx=2, src_val=1000, Ez_old={10,20,30,40}, Hy={5,7,4,4}, streamed back-to-back, out_ready=1.
  - Expected: Ez_n_o = {0,22,1027,40}.
  - Expected: first out_valid 3 cycles after the first accept, out_last on the 4th output, done with the 4th handshake.
- Truncation:
  - Setup: n_cells=3, ceze=0, cezh=1<<20, Hy={0,3,0}.
  - Expected: outputs {0,1,−2}, from floor(1.5) and floor(−1.5).
- Backpressure:
  - Setup: basic frame with out_ready low for 5 cycles after the first out_valid.
  - Expected: in_ready drops while stalled, Ez_n_o holds at 0, then the identical sequence follows with no loss or duplication.
- Bubbles and edge cases:
  - in_valid toggled 1,0,1,0: outputs are spaced identically, values unchanged.
  - n_cells=0 start: done one cycle later, busy never set.
- Reset mid-frame:
  - Setup: RST_N asserted after 2 of 4 inputs are accepted.
  - Expected: all outputs 0 immediately.
  - Follow-up: a new start with the basic stimulus again yields {0,22,1027,40}, showing Hy_prev was re-zeroed.
